trivium_stream_top: RTL and testbench

Bit-serial Trivium stream-cipher core. A host shifts in an 80-bit key and an 80-bit IV one bit per clock, then pulses a load strobe. The core runs the 1152-round Trivium warm-up and raises a ready flag. After that it encrypts (or decrypts) a serial data stream by XORing each input bit with one keystream bit. It sits between a serial host/controller and the data path and has no bus interface.

---
 rtl/trivium_stream_top_if.sv | 11 +
 rtl/trivium_stream_top.sv | 63 ++++++
 tb/tb_trivium_stream_top.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/trivium_stream_top_if.sv
// trivium_stream_if: serial host <-> Trivium core signals
interface trivium_stream_if;
  logic dat_i;
  logic get_dat_i;
  logic ld_keys_i;
  logic end_i;
  logic dat_o;
  logic ready_o;
  modport master (output dat_i, get_dat_i, ld_keys_i, end_i, input dat_o, ready_o);
  modport slave (input dat_i, get_dat_i, ld_keys_i, end_i, output dat_o, ready_o);
endinterface

// File: rtl/trivium_stream_top.sv
// trivium_stream_top: bit-serial Trivium core with key/IV capture, 1152-round warm-up and XOR stream
module trivium_stream_top (
  input logic clk_i,
  input logic n_rst_i,
  trivium_stream_if.slave bus
);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  logic [1:0] state;
  logic [287:0] s, s_nxt, s_ld;
  logic [159:0] cap;
  logic [10:0] cnt;
  logic ready;
  logic t1, t2, t3, z, t1n, t2n, t3n;
  // s[n-1] holds Trivium bit s(n)
  always_comb begin
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z = t1 ^ t2 ^ t3;
    t1n = t1 ^ (s[90] & s[91]) ^ s[170];
    t2n = t2 ^ (s[174] & s[175]) ^ s[263];
    t3n = t3 ^ (s[285] & s[286]) ^ s[68];
    s_nxt = {s[286:177], t2n, s[175:93], t1n, s[91:0], t3n};
    s_ld = {3'b111, 112'b0, cap[159:80], 13'b0, cap[79:0]};
  end
  assign bus.dat_o = (state == RUN && bus.get_dat_i && !bus.end_i) ? bus.dat_i ^ z : 1'b0;
  assign bus.ready_o = ready;
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state <= LOAD;
      s <= '0;
      cap <= '0;
      cnt <= '0;
      ready <= 1'b0;
    end else if (bus.end_i) begin
      state <= LOAD;
      ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.get_dat_i) cap <= {bus.dat_i, cap[159:1]};
          if (bus.ld_keys_i) begin
            s <= s_ld;
            cnt <= '0;
            state <= INIT;
          end
        end
        INIT: begin
          s <= s_nxt;
          cnt <= cnt + 11'd1;
          if (cnt == 11'd1151) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: if (bus.get_dat_i) s <= s_nxt;
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_trivium_stream_top.sv
// tb_trivium_stream_top: randomized checks of the Trivium core against a bit-array cipher model
module tb_trivium_stream_top;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic obs;
  logic [79:0] mk, miv;
  logic [63:0] mpt, mct;
  bit st [1:288];
  trivium_stream_if bus ();
  trivium_stream_top dut (.clk_i(clk), .n_rst_i(n_rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit m_step();
    bit t1, t2, t3, z, a, b, c;
    t1 = st[66] ^ st[93];
    t2 = st[162] ^ st[177];
    t3 = st[243] ^ st[288];
    z = t1 ^ t2 ^ t3;
    a = t1 ^ (st[91] & st[92]) ^ st[171];
    b = t2 ^ (st[175] & st[176]) ^ st[264];
    c = t3 ^ (st[286] & st[287]) ^ st[69];
    for (int i = 93; i > 1; i--) st[i] = st[i-1];
    st[1] = c;
    for (int i = 177; i > 94; i--) st[i] = st[i-1];
    st[94] = a;
    for (int i = 288; i > 178; i--) st[i] = st[i-1];
    st[178] = b;
    return z;
  endfunction
  function automatic void m_load(input logic [79:0] k, input logic [79:0] iv);
    for (int i = 1; i <= 288; i++) st[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      st[i+1] = k[i];
      st[94+i] = iv[i];
    end
    st[286] = 1'b1;
    st[287] = 1'b1;
    st[288] = 1'b1;
    repeat (1152) void'(m_step());
  endfunction
  task automatic cyc(input logic d, input logic g, input logic l, input logic e);
    @(negedge clk);
    bus.dat_i = d;
    bus.get_dat_i = g;
    bus.ld_keys_i = l;
    bus.end_i = e;
    #1 obs = bus.dat_o;
    @(posedge clk);
    #1;
  endtask
  task automatic send_keys(input logic [79:0] k, input logic [79:0] iv, input int extra);
    repeat (extra) cyc(1'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) cyc(k[i], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) cyc(iv[i], 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    m_load(k, iv);
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 1300) begin
      cyc(1'($urandom), 1'($urandom), 1'b0, 1'b0);
      n++;
    end
  endtask
  task automatic test_reset();
    n_rst = 1'b0;
    repeat (5) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks += 2;
      if (obs !== 1'b0) begin errors++; $display("FAIL reset_dat: got %b want 0", obs); end
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
    end
    n_rst = 1'b1;
    repeat (4) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== 1'b0) begin errors++; $display("FAIL load_dat: got %b want 0", obs); end
    end
  endtask
  task automatic test_warmup();
    int n;
    send_keys('0, '0, 0);
    wait_ready(n);
    checks++;
    if (n !== 1152) begin errors++; $display("FAIL warmup_edges: got %0d want 1152", n); end
  endtask
  task automatic test_golden();
    int n;
    logic ks [32];
    logic e;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      e = m_step();
      ks[i] = obs;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL golden0 bit %0d: got %b want %b", i, obs, e); end
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    checks += 2;
    if (obs !== 1'b0) begin errors++; $display("FAIL end_get_dat: got %b want 0", obs); end
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL end_ready: got %b want 0", bus.ready_o); end
    send_keys('0, '0, 0);
    wait_ready(n);
    checks++;
    if (n !== 1152) begin errors++; $display("FAIL golden_warmup: got %0d want 1152", n); end
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      e = ~m_step();
      checks += 2;
      if (obs !== e) begin errors++; $display("FAIL golden1 bit %0d: got %b want %b", i, obs, e); end
      if (obs !== ~ks[i]) begin errors++; $display("FAIL golden_compl bit %0d: got %b want %b", i, obs, ~ks[i]); end
    end
  endtask
  task automatic test_gapped();
    logic d, e;
    int g = 0;
    for (int i = 0; i < 32; i++) begin
      if (g < 10 && (i % 3 == 1)) begin
        cyc(1'($urandom), 1'b0, 1'(g == 4), 1'b0);
        g++;
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL gap_dat: got %b want 0", obs); end
      end
      d = 1'($urandom);
      cyc(d, 1'b1, 1'b0, 1'b0);
      e = d ^ m_step();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL gapped bit %0d: got %b want %b", i, obs, e); end
    end
  endtask
  task automatic test_multi();
    int n;
    logic e;
    mk = 80'h0123456789ABCDEF0123;
    miv = 80'h3210FEDCBA9876543210;
    mpt = {$urandom, $urandom};
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL multi_end_ready: got %b want 0", bus.ready_o); end
    send_keys(mk, miv, 37);
    wait_ready(n);
    checks++;
    if (n !== 1152) begin errors++; $display("FAIL multi_warmup: got %0d want 1152", n); end
    for (int i = 0; i < 64; i++) begin
      cyc(mpt[i], 1'b1, 1'b0, 1'b0);
      e = mpt[i] ^ m_step();
      mct[i] = obs;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL multi bit %0d: got %b want %b", i, obs, e); end
    end
  endtask
  task automatic test_round_trip();
    int n;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_keys(mk, miv, 0);
    wait_ready(n);
    checks++;
    if (n !== 1152) begin errors++; $display("FAIL rt_warmup: got %0d want 1152", n); end
    for (int i = 0; i < 64; i++) begin
      cyc(mct[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== mpt[i]) begin errors++; $display("FAIL round_trip bit %0d: got %b want %b", i, obs, mpt[i]); end
    end
  endtask
  task automatic test_reset_mid_init();
    int n;
    int rose = 0;
    logic e;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_keys(mk, miv, 0);
    repeat (500) cyc(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    n_rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    repeat (1300) begin
      cyc(1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (bus.ready_o !== 1'b0) rose++;
    end
    checks++;
    if (rose !== 0) begin errors++; $display("FAIL reset_mid_init: ready high %0d cycles want 0", rose); end
    send_keys(mk, miv, 0);
    wait_ready(n);
    checks++;
    if (n !== 1152) begin errors++; $display("FAIL reload_warmup: got %0d want 1152", n); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      e = m_step();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reload bit %0d: got %b want %b", i, obs, e); end
    end
  endtask
  initial begin
    bus.dat_i = 1'b0;
    bus.get_dat_i = 1'b0;
    bus.ld_keys_i = 1'b0;
    bus.end_i = 1'b0;
    test_reset();
    test_warmup();
    test_golden();
    test_gapped();
    test_multi();
    test_round_trip();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
